// File: rtl/imem_loader.sv
// ---------------------------------------------------------------------------
// imem_loader
//
// Boot-time instruction-memory loader. A host streams bytes in over a
// valid/ready handshake. The first two bytes form a 16-bit big-endian word
// count N. The next 4*N bytes are packed MSB-first into 32-bit words and
// written to consecutive word addresses starting at 0. The processor is held
// in reset (cpu_reset_n=0) until the last word has been written.
//
// Handshake: a byte transfers on a rising clk edge where in_valid and
// in_ready are both 1. in_ready is a registered output, so the loader only
// counts a byte when it advertised readiness in that cycle. A byte that the
// host holds while in_ready=0 is therefore never counted twice.
//
// Ports
//   clk          system clock, rising-edge active
//   reset_n      asynchronous active-low reset
//   in_data      host byte
//   in_valid     in_data is valid
//   in_ready     loader accepts a byte this cycle
//   mem_we       instruction-memory write strobe, one cycle per word
//   mem_addr     word address of the write
//   mem_wdata    word to write
//   cpu_reset_n  active-low processor reset, released after a good load
//   done         load complete, sticky until reset
//   error        header count exceeds capacity, sticky until reset
//   state_dbg    current FSM state encoding, for observation only
// ---------------------------------------------------------------------------
module imem_loader #(
   parameter int ADDR_WIDTH = 8
) (
   input  logic                  clk,
   input  logic                  reset_n,
   input  logic [7:0]            in_data,
   input  logic                  in_valid,
   output logic                  in_ready,
   output logic                  mem_we,
   output logic [ADDR_WIDTH-1:0] mem_addr,
   output logic [31:0]           mem_wdata,
   output logic                  cpu_reset_n,
   output logic                  done,
   output logic                  error,
   output logic [2:0]            state_dbg
);

   typedef enum logic [2:0] {
      START  = 3'd0,
      HDR_HI = 3'd1,
      HDR_LO = 3'd2,
      DATA   = 3'd3,
      RUN    = 3'd4,
      ERROR  = 3'd5
   } state_t;

   // Memory capacity in words, wide enough to hold 2^ADDR_WIDTH itself.
   localparam logic [16:0] CAPACITY = 17'(1) << ADDR_WIDTH;

   state_t                state, state_nxt;
   logic [15:0]           count, count_nxt;
   // One bit wider than the address so that N = 2^ADDR_WIDTH can be reached.
   logic [ADDR_WIDTH:0]   word_cnt, word_cnt_nxt;
   logic [ADDR_WIDTH:0]   word_cnt_inc;
   logic [1:0]            byte_idx, byte_idx_nxt;
   // First three bytes of the word being assembled, oldest in the top byte.
   logic [23:0]           word_buf, word_buf_nxt;
   logic [15:0]           hdr_n;
   logic                  xfer;

   logic                  in_ready_nxt;
   logic                  mem_we_nxt;
   logic [ADDR_WIDTH-1:0] mem_addr_nxt;
   logic [31:0]           mem_wdata_nxt;
   logic                  cpu_reset_n_nxt;
   logic                  done_nxt;
   logic                  error_nxt;

   assign xfer         = in_valid && in_ready;
   assign hdr_n        = {count[15:8], in_data};
   assign word_cnt_inc = word_cnt + 1'b1;
   assign state_dbg    = state;

   // State and all outputs are registered together.
   always_ff @(posedge clk or negedge reset_n) begin
      if (!reset_n) begin
         state       <= START;
         count       <= '0;
         word_cnt    <= '0;
         byte_idx    <= '0;
         word_buf    <= '0;
         in_ready    <= 1'b0;
         mem_we      <= 1'b0;
         mem_addr    <= '0;
         mem_wdata   <= '0;
         cpu_reset_n <= 1'b0;
         done        <= 1'b0;
         error       <= 1'b0;
      end else begin
         state       <= state_nxt;
         count       <= count_nxt;
         word_cnt    <= word_cnt_nxt;
         byte_idx    <= byte_idx_nxt;
         word_buf    <= word_buf_nxt;
         in_ready    <= in_ready_nxt;
         mem_we      <= mem_we_nxt;
         mem_addr    <= mem_addr_nxt;
         mem_wdata   <= mem_wdata_nxt;
         cpu_reset_n <= cpu_reset_n_nxt;
         done        <= done_nxt;
         error       <= error_nxt;
      end
   end

   always_comb begin
      state_nxt       = state;
      count_nxt       = count;
      word_cnt_nxt    = word_cnt;
      byte_idx_nxt    = byte_idx;
      word_buf_nxt    = word_buf;
      in_ready_nxt    = in_ready;
      mem_we_nxt      = 1'b0;
      mem_addr_nxt    = mem_addr;
      mem_wdata_nxt   = mem_wdata;
      cpu_reset_n_nxt = cpu_reset_n;
      done_nxt        = done;
      error_nxt       = error;

      case (state)
         START: begin
            state_nxt    = HDR_HI;
            in_ready_nxt = 1'b1;
         end

         HDR_HI: begin
            if (xfer) begin
               count_nxt[15:8] = in_data;
               state_nxt       = HDR_LO;
            end
         end

         HDR_LO: begin
            if (xfer) begin
               count_nxt = hdr_n;
               if (hdr_n == 16'd0) begin
                  state_nxt       = RUN;
                  in_ready_nxt    = 1'b0;
                  cpu_reset_n_nxt = 1'b1;
                  done_nxt        = 1'b1;
               end else if ({1'b0, hdr_n} > CAPACITY) begin
                  state_nxt    = ERROR;
                  in_ready_nxt = 1'b0;
                  error_nxt    = 1'b1;
               end else begin
                  state_nxt    = DATA;
                  word_cnt_nxt = '0;
                  byte_idx_nxt = '0;
               end
            end
         end

         DATA: begin
            if (xfer) begin
               if (byte_idx == 2'd3) begin
                  mem_wdata_nxt = {word_buf, in_data};
                  mem_addr_nxt  = word_cnt[ADDR_WIDTH-1:0];
                  mem_we_nxt    = 1'b1;
                  word_cnt_nxt  = word_cnt_inc;
                  byte_idx_nxt  = 2'd0;
                  // Stop accepting at the same edge that takes the last byte.
                  if (17'(word_cnt_inc) == {1'b0, count}) begin
                     in_ready_nxt = 1'b0;
                  end
               end else begin
                  word_buf_nxt = {word_buf[15:0], in_data};
                  byte_idx_nxt = byte_idx + 2'd1;
               end
            end else if (!in_ready) begin
               // in_ready is only low in DATA during the final write cycle,
               // so this edge ends the last mem_we pulse.
               state_nxt       = RUN;
               cpu_reset_n_nxt = 1'b1;
               done_nxt        = 1'b1;
            end
         end

         RUN: begin
            in_ready_nxt    = 1'b0;
            cpu_reset_n_nxt = 1'b1;
            done_nxt        = 1'b1;
         end

         ERROR: begin
            in_ready_nxt    = 1'b0;
            cpu_reset_n_nxt = 1'b0;
            error_nxt       = 1'b1;
         end

         default: begin
            state_nxt = START;
         end
      endcase
   end

endmodule
